// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters.
// Ports: clk, reset (async, active-high); req0_*/req1_* valid/ready
//   operand requests; alu_rs/alu_rt/alu_op drive the ALU and alu_result
//   returns from it; resp_valid/resp_ready/resp_id/resp_data carry the
//   response; busy is high whenever the FSM is not IDLE.
// Optional: define ALU_ARB_STATS_EN to add the saturating per-requester
//   completion counters stat_cnt0/stat_cnt1.
module alu_arbiter #(
    parameter int DATA_W      = 4,
    parameter int OP_W        = 2,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_rs,
    input  logic [DATA_W-1:0] req0_rt,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_rs,
    input  logic [DATA_W-1:0] req1_rt,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_rs,
    output logic [DATA_W-1:0] alu_rt,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]        stat_cnt0,
    output logic [7:0]        stat_cnt1
`endif
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             grant;
    logic             any_valid;
    logic             idle;

    // With both requesting, the one not served last wins; a lone
    // requester wins regardless of history.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign any_valid = req0_valid | req1_valid;

    // Ready is held low while reset is asserted so every output reads 0.
    assign idle       = (state == IDLE) && !reset;
    assign req0_ready = idle && req0_valid && !grant;
    assign req1_ready = idle && req1_valid && grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            alu_rs     <= '0;
            alu_rt     <= '0;
            alu_op     <= '0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_rs     <= grant ? req1_rs : req0_rs;
                        alu_rt     <= grant ? req1_rt : req0_rt;
                        alu_op     <= grant ? req1_op : req0_op;
                        resp_id    <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_W'(ALU_LATENCY);
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt==0 marks the last of ALU_LATENCY+1 wait cycles.
                    if (cnt == '0) begin
                        resp_data  <= alu_result;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic done;

    assign done = resp_valid && resp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cnt0 <= 8'd0;
            stat_cnt1 <= 8'd0;
        end else if (done) begin
            if (!resp_id && stat_cnt0 != 8'hff) begin
                stat_cnt0 <= stat_cnt0 + 8'd1;
            end
            if (resp_id && stat_cnt1 != 8'hff) begin
                stat_cnt1 <= stat_cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter with a small ALU model.
// Main instance uses ALU_LATENCY=1; two side instances use 0 and 3.
module tb_alu_arbiter;

    typedef struct {
        bit         id;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [1:0] op;
        logic [3:0] exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_rs, req0_rt, req1_rs, req1_rt;
    logic [1:0] req0_op, req1_op;
    logic [3:0] alu_rs, alu_rt, alu_result, resp_data;
    logic [1:0] alu_op;
    logic       resp_valid, resp_ready, resp_id, busy;
`ifdef ALU_ARB_STATS_EN
    logic [7:0] stat_cnt0, stat_cnt1;
    logic [7:0] xs0 [2];
    logic [7:0] xs1 [2];
`endif

    // Side instances: index 0 -> ALU_LATENCY=0, index 1 -> ALU_LATENCY=3.
    logic       x_v    [2];
    logic       x_rdy  [2];
    logic       x_r1rdy[2];
    logic [3:0] x_ars  [2];
    logic [3:0] x_art  [2];
    logic [1:0] x_aop  [2];
    logic [3:0] x_res  [2];
    logic       x_rv   [2];
    logic       x_rid  [2];
    logic [3:0] x_rd   [2];
    logic       x_busy [2];
    logic       one;
    logic       zero;
    logic [3:0] z4;
    logic [1:0] z2;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b,
                                         logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) alu_result <= alu_f(alu_rs, alu_rt, alu_op);

    logic [3:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= alu_f(x_ars[1], x_art[1], x_aop[1]);
        p2 <= p1;
        p3 <= p2;
    end
    assign x_res[0] = alu_f(x_ars[0], x_art[0], x_aop[0]);
    assign x_res[1] = p3;

    alu_arbiter #(.ALU_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs(req0_rs), .req0_rt(req0_rt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs(req1_rs), .req1_rt(req1_rt), .req1_op(req1_op),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
    );

    alu_arbiter #(.ALU_LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset),
        .req0_valid(x_v[0]), .req0_ready(x_rdy[0]),
        .req0_rs(4'd15), .req0_rt(4'd1), .req0_op(2'd0),
        .req1_valid(zero), .req1_ready(x_r1rdy[0]),
        .req1_rs(z4), .req1_rt(z4), .req1_op(z2),
        .alu_rs(x_ars[0]), .alu_rt(x_art[0]), .alu_op(x_aop[0]),
        .alu_result(x_res[0]),
        .resp_valid(x_rv[0]), .resp_ready(one),
        .resp_id(x_rid[0]), .resp_data(x_rd[0]), .busy(x_busy[0])
`ifdef ALU_ARB_STATS_EN
        , .stat_cnt0(xs0[0]), .stat_cnt1(xs1[0])
`endif
    );

    alu_arbiter #(.ALU_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset),
        .req0_valid(x_v[1]), .req0_ready(x_rdy[1]),
        .req0_rs(4'd15), .req0_rt(4'd1), .req0_op(2'd0),
        .req1_valid(zero), .req1_ready(x_r1rdy[1]),
        .req1_rs(z4), .req1_rt(z4), .req1_op(z2),
        .alu_rs(x_ars[1]), .alu_rt(x_art[1]), .alu_op(x_aop[1]),
        .alu_result(x_res[1]),
        .resp_valid(x_rv[1]), .resp_ready(one),
        .resp_id(x_rid[1]), .resp_data(x_rd[1]), .busy(x_busy[1])
`ifdef ALU_ARB_STATS_EN
        , .stat_cnt0(xs0[1]), .stat_cnt1(xs1[1])
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called just after the handshake edge; counts edges to resp_valid.
    task automatic wait_resp(input string nm, input int id, input int data,
                             input int lat);
        int got = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                got = k;
                break;
            end
        end
        chk({nm, "_lat"}, got, lat);
        chk({nm, "_id"}, int'(resp_id), id);
        chk({nm, "_data"}, int'(resp_data), data);
    endtask

    task automatic run_op(input string nm, input vec_t v);
        if (v.id) begin
            req1_valid = 1'b1;
            req1_rs = v.rs; req1_rt = v.rt; req1_op = v.op;
        end else begin
            req0_valid = 1'b1;
            req0_rs = v.rs; req0_rt = v.rt; req0_op = v.op;
        end
        #1;
        chk({nm, "_ready"}, int'(v.id ? req1_ready : req0_ready), 1);
        chk({nm, "_other"}, int'(v.id ? req0_ready : req1_ready), 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({nm, "_alu"}, int'({alu_rs, alu_rt, alu_op, busy}),
            int'({v.rs, v.rt, v.op, 1'b1}));
        wait_resp(nm, int'(v.id), int'(v.exp), 2);
        @(posedge clk);
        #1;
        chk({nm, "_idle"}, int'({busy, resp_valid}), 0);
    endtask

    vec_t vecs[6];

    initial begin
        int gq[$];
        int dq[$];
        int both;
        int nresp;
        int cnt_rv;
        int lat;

        vecs[0] = '{1'b0, 4'd3,  4'd4,  2'd0, 4'd7};
        vecs[1] = '{1'b1, 4'd15, 4'd1,  2'd0, 4'd0};
        vecs[2] = '{1'b1, 4'd5,  4'd3,  2'd1, 4'd2};
        vecs[3] = '{1'b0, 4'd12, 4'd10, 2'd2, 4'd8};
        vecs[4] = '{1'b0, 4'd12, 4'd10, 2'd3, 4'd14};
        vecs[5] = '{1'b1, 4'd9,  4'd9,  2'd0, 4'd2};

        one = 1'b1; zero = 1'b0; z4 = 4'd0; z2 = 2'd0;
        x_v[0] = 1'b0; x_v[1] = 1'b0;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_rs = 0; req0_rt = 0; req0_op = 0;
        req1_rs = 0; req1_rt = 0; req1_op = 0;
        resp_ready = 1'b1;
        #2;
        chk("reset_outs",
            int'({busy, resp_valid, resp_id, resp_data, alu_rs, alu_rt,
                  alu_op, req0_ready, req1_ready}), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Both requesting: last grant was 1, so 0,1,0,1 follows.
        req0_valid = 1; req0_rs = 9; req0_rt = 9; req0_op = 0;
        req1_valid = 1; req1_rs = 1; req1_rt = 2; req1_op = 0;
        both = 0;
        nresp = 0;
        for (int c = 0; c < 60 && nresp < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            if (resp_valid) begin
                dq.push_back(int'(resp_data));
                nresp++;
            end
            if (nresp < 4) begin
                @(posedge clk);
                #1;
            end
        end
        req0_valid = 0;
        req1_valid = 0;
        chk("alt_both_ready", both, 0);
        chk("alt_ngrant", gq.size(), 4);
        chk("alt_nresp", dq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("alt_grant%0d", i),
                (i < gq.size()) ? gq[i] : -1, i % 2);
            chk($sformatf("alt_data%0d", i),
                (i < dq.size()) ? dq[i] : -1, (i % 2) ? 3 : 2);
        end
        @(posedge clk);
        #1;
        chk("alt_idle", int'(busy), 0);

        // Back-pressure on the response.
        resp_ready = 0;
        req1_valid = 1; req1_rs = 2; req1_rt = 2; req1_op = 0;
        #1;
        @(posedge clk);
        #1;
        req1_valid = 0;
        wait_resp("bp", 1, 4, 2);
        req0_valid = 1; req0_rs = 6; req0_rt = 1; req0_op = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", c),
                int'({resp_valid, resp_id, resp_data, req0_ready}),
                int'({1'b1, 1'b1, 4'd4, 1'b0}));
        end
        resp_ready = 1;
        @(posedge clk);
        #1;
        chk("bp_next_ready", int'(req0_ready), 1);
        @(posedge clk);
        #1;
        req0_valid = 0;
        wait_resp("bp_next", 0, 7, 2);
        @(posedge clk);
        #1;

        // Reset while req1 is waiting on the ALU.
        req1_valid = 1; req1_rs = 7; req1_rt = 7; req1_op = 0;
        #1;
        @(posedge clk);
        #1;
        req1_valid = 0;
        chk("rst_inflight_busy", int'(busy), 1);
        reset = 1;
        #1;
        chk("rst_async_outs",
            int'({busy, resp_valid, resp_id, resp_data, alu_rs, alu_rt,
                  alu_op, req0_ready, req1_ready}), 0);
        @(posedge clk);
        #1;
        reset = 0;
        cnt_rv = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid) cnt_rv++;
        end
        chk("rst_no_resp", cnt_rv, 0);
        req0_valid = 1; req0_rs = 1; req0_rt = 1; req0_op = 0;
        req1_valid = 1; req1_rs = 3; req1_rt = 3; req1_op = 0;
        #1;
        chk("rst_first_grant", int'({req0_ready, req1_ready}), 2);
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        wait_resp("rst_after", 0, 2, 2);
        @(posedge clk);
        #1;

        // Latency 0 and 3 builds: 15+1 wraps to 0.
        for (int i = 0; i < 2; i++) begin
            x_v[i] = 1'b1;
            #1;
            chk($sformatf("lat_ready%0d", i), int'(x_rdy[i]), 1);
            @(posedge clk);
            #1;
            x_v[i] = 1'b0;
            lat = 0;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk);
                #1;
                if (x_rv[i]) begin
                    lat = k;
                    break;
                end
            end
            chk($sformatf("lat_edges%0d", i), lat, i ? 4 : 1);
            chk($sformatf("lat_data%0d", i), int'({x_rid[i], x_rd[i]}), 0);
            @(posedge clk);
            #1;
        end

`ifdef ALU_ARB_STATS_EN
        reset = 1;
        #1;
        chk("stat_reset", int'({stat_cnt0, stat_cnt1}), 0);
        @(posedge clk);
        #1;
        reset = 0;
        for (int id = 0; id < 2; id++) begin
            nresp = 0;
            if (id == 0) req0_valid = 1;
            else req1_valid = 1;
            for (int c = 0; c < 3000 && nresp < (id ? 2 : 300); c++) begin
                @(posedge clk);
                #1;
                if (resp_valid && resp_ready) nresp++;
            end
            req0_valid = 0;
            req1_valid = 0;
            chk($sformatf("stat_runs%0d", id), nresp, id ? 2 : 300);
            @(posedge clk);
            #1;
        end
        chk("stat_cnt0", int'(stat_cnt0), 255);
        chk("stat_cnt1", int'(stat_cnt1), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
